// File: rtl/mem_ddr_loader.sv
// DDR-to-SRAM beat loader: issues aligned 32-byte DDR reads, buffers returns and streams rows to the farm demux.
// Optional statistics counters are enabled by defining MEM_DDR_LOADER_STATS_EN.
module mem_ddr_loader #(
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       cmd_ddr_addr,
  input  logic [18:0]       cmd_sram_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic              ddr_req,
  output logic [31:0]       ddr_addr,
  input  logic              ddr_ack,
  input  logic              ddr_valid,
  input  logic [DATA_W-1:0] ddr_data,
  output logic              farm_valid,
  output logic [DATA_W-1:0] farm_data,
  output logic [18:0]       farm_base_addr,
  output logic              farm_last,
  output logic [4:0]        farm_last_bytes,
  input  logic              farm_busy,
`ifdef MEM_DDR_LOADER_STATS_EN
  output logic [31:0]       stat_beats,
  output logic [31:0]       stat_stall,
`endif
  output logic [1:0]        dbg_state
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BEAT_W = LEN_W - 4;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [4:0]          len_lo_q;
  logic [18:0]         row_q;
  logic [31:0]         addr_q;
  logic [BEAT_W-1:0]   req_left_q, beats_left_q;
  logic [CNT_W-1:0]    out_q, out_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic [LEN_W:0]      len_round;
  logic [BEAT_W-1:0]   cmd_beats;
  logic [CNT_W:0]      in_flight;
  logic                accept, push, pop, cmd_take;

  // Handshake: a DDR request completes on req&ack; a farm beat transfers on farm_valid&!farm_busy.
  assign len_round = {1'b0, cmd_len} + (LEN_W+1)'(31);
  assign cmd_beats = len_round[LEN_W:5];
  assign in_flight = {1'b0, out_q} + {1'b0, cnt_q};
  assign cmd_take  = (state_q == S_IDLE) && start;

  assign ddr_req  = (state_q == S_FETCH) && (req_left_q != '0) &&
                    (in_flight < (CNT_W+1)'(FIFO_DEPTH));
  assign ddr_addr = addr_q;
  assign accept   = ddr_req && ddr_ack;
  // Returns seen while idle are leftovers from an aborted command and are dropped.
  assign push     = ddr_valid && (state_q != S_IDLE);

  assign farm_valid      = (cnt_q != '0);
  assign farm_data       = mem_q[rd_ptr_q];
  assign farm_base_addr  = row_q;
  assign farm_last       = farm_valid && (beats_left_q == BEAT_W'(1));
  assign farm_last_bytes = farm_last ? len_lo_q : 5'd0;
  assign pop             = farm_valid && !farm_busy;

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (cmd_len == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (accept && (req_left_q == BEAT_W'(1))) state_d = S_DRAIN;
      S_DRAIN: if (pop && farm_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (accept) out_d = out_d + CNT_W'(1);
    if (push && (out_d != '0)) out_d = out_d - CNT_W'(1);
    cnt_d = cnt_q;
    if (push) cnt_d = cnt_d + CNT_W'(1);
    if (pop)  cnt_d = cnt_d - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      req_left_q   <= '0;
      beats_left_q <= '0;
      out_q        <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (cmd_take) begin
        len_lo_q     <= cmd_len[4:0];
        row_q        <= cmd_sram_addr;
        addr_q       <= {cmd_ddr_addr[31:5], 5'd0};
        req_left_q   <= cmd_beats;
        beats_left_q <= cmd_beats;
      end else begin
        if (accept) begin
          addr_q     <= addr_q + 32'd32;
          req_left_q <= req_left_q - BEAT_W'(1);
        end
        if (pop) begin
          row_q        <= row_q + 19'd1;
          beats_left_q <= beats_left_q - BEAT_W'(1);
        end
      end
    end
  end

  // Beat storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ddr_data;
  end

`ifdef MEM_DDR_LOADER_STATS_EN
  logic [31:0] stat_beats_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_beats_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (pop && (stat_beats_q != '1)) stat_beats_q <= stat_beats_q + 32'd1;
      if (farm_valid && farm_busy && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_beats = stat_beats_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_mem_ddr_loader.sv
// Directed bench for mem_ddr_loader: a DDR responder, a command-level model and a per-cycle compare process.
module tb_mem_ddr_loader;

  localparam int DATA_W = 256;
  localparam int DEPTH  = 4;
  localparam int LEN_W  = 16;

  logic              clk, rst, start;
  logic [31:0]       cmd_ddr_addr;
  logic [18:0]       cmd_sram_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              busy, done, ddr_req, ddr_ack, ddr_valid;
  logic [31:0]       ddr_addr;
  logic [DATA_W-1:0] ddr_data, farm_data;
  logic              farm_valid, farm_last, farm_busy;
  logic [18:0]       farm_base_addr;
  logic [4:0]        farm_last_bytes;
  logic [1:0]        dbg_state;
`ifdef MEM_DDR_LOADER_STATS_EN
  logic [31:0]       stat_beats, stat_stall;
`endif

  mem_ddr_loader #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmd_ddr_addr(cmd_ddr_addr), .cmd_sram_addr(cmd_sram_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done),
    .ddr_req(ddr_req), .ddr_addr(ddr_addr), .ddr_ack(ddr_ack),
    .ddr_valid(ddr_valid), .ddr_data(ddr_data),
    .farm_valid(farm_valid), .farm_data(farm_data), .farm_base_addr(farm_base_addr),
    .farm_last(farm_last), .farm_last_bytes(farm_last_bytes), .farm_busy(farm_busy),
`ifdef MEM_DDR_LOADER_STATS_EN
    .stat_beats(stat_beats), .stat_stall(stat_stall),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [31:0] a);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = a ^ (32'h5A00_0000 + 32'(i));
    return r;
  endfunction

  // ---------------- DDR responder ----------------
  int          ret_lat = 0;
  int          cyc = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  always @(negedge clk) begin
    cyc++;
    ddr_valid = 1'b0;
    ddr_data  = '0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      ddr_valid = 1'b1;
      ddr_data  = pat(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (ddr_req === 1'b1 && ddr_ack === 1'b1) begin
      pend_addr.push_back(ddr_addr);
      pend_due.push_back(cyc + 1 + ret_lat);
    end
  end

  // ---------------- model + scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [18:0]       exp_row_q[$];
  logic              exp_last_q[$];
  logic [4:0]        exp_lb_q[$];
  logic [31:0]       req_q[$];
  logic [31:0]       acc_log[$];
  logic [18:0]       row_log[$];
  logic [4:0]        lb_log[$];
  logic              m_busy = 1'b0;
  logic              done_due = 1'b0;
  int                acc_cnt = 0, xfer_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    logic busy_now, nxt_done, cap_ok;
    if (rst) begin
      exp_q.delete(); exp_row_q.delete(); exp_last_q.delete(); exp_lb_q.delete(); req_q.delete();
      m_busy = 1'b0; done_due = 1'b0; acc_cnt = 0; xfer_cnt = 0;
    end else begin
      busy_now = m_busy;
      nxt_done = 1'b0;
      cap_ok   = (acc_cnt - xfer_cnt) < DEPTH;
      chk("busy", DATA_W'(busy), DATA_W'(m_busy));
      chk("done", DATA_W'(done), DATA_W'(done_due));
      if (done === 1'b1) done_cnt++;
      if (done_due) m_busy = 1'b0;
      if (exp_row_q.size() == 0) begin
        chk("farm_valid_unexpected", DATA_W'(farm_valid), '0);
      end else if (farm_valid === 1'b1) begin
        chk("farm_data", farm_data, exp_q[0]);
        chk("farm_base_addr", DATA_W'(farm_base_addr), DATA_W'(exp_row_q[0]));
        chk("farm_last", DATA_W'(farm_last), DATA_W'(exp_last_q[0]));
        chk("farm_last_bytes", DATA_W'(farm_last_bytes), DATA_W'(exp_lb_q[0]));
        if (farm_busy == 1'b0) begin
          row_log.push_back(exp_row_q[0]);
          lb_log.push_back(exp_lb_q[0]);
          if (exp_last_q[0]) nxt_done = 1'b1;
          void'(exp_q.pop_front()); void'(exp_row_q.pop_front());
          void'(exp_last_q.pop_front()); void'(exp_lb_q.pop_front());
          xfer_cnt++;
        end
      end
      if (req_q.size() == 0) begin
        chk("ddr_req_unexpected", DATA_W'(ddr_req), '0);
      end else if (ddr_req === 1'b1) begin
        chk("req_cap", DATA_W'(cap_ok), DATA_W'(1));
        if (ddr_ack) begin
          chk("ddr_addr", DATA_W'(ddr_addr), DATA_W'(req_q[0]));
          acc_log.push_back(ddr_addr);
          void'(req_q.pop_front());
          acc_cnt++;
        end
      end
      if (start && !busy_now) begin
        int beats;
        logic [31:0] base;
        acc_log.delete(); row_log.delete(); lb_log.delete();
        m_busy = 1'b1;
        beats  = (int'(cmd_len) + 31) / 32;
        base   = {cmd_ddr_addr[31:5], 5'd0};
        if (beats == 0) nxt_done = 1'b1;
        for (int i = 0; i < beats; i++) begin
          req_q.push_back(base + 32'(32*i));
          exp_q.push_back(pat(base + 32'(32*i)));
          exp_row_q.push_back(19'(cmd_sram_addr + 19'(i)));
          exp_last_q.push_back(i == beats-1);
          exp_lb_q.push_back((i == beats-1) ? 5'(cmd_len % 32) : 5'd0);
        end
      end
      done_due = nxt_done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cmd(input logic [31:0] a, input logic [18:0] s, input int len);
    @(posedge clk); #1;
    cmd_ddr_addr  = a;
    cmd_sram_addr = s;
    cmd_len       = LEN_W'(len);
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((m_busy || busy !== 1'b0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL %s_timeout busy=%0b expected idle", name, busy);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, n;
    rst = 1'b1; start = 1'b0; cmd_ddr_addr = '0; cmd_sram_addr = '0; cmd_len = '0;
    ddr_ack = 1'b0; farm_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_ddr_addr", DATA_W'(ddr_addr), '0);
    chk("rst_farm_base_addr", DATA_W'(farm_base_addr), '0);
    chk("rst_farm_last_bytes", DATA_W'(farm_last_bytes), '0);
    chk("rst_farm_last", DATA_W'(farm_last), '0);
    chk("rst_ddr_req", DATA_W'(ddr_req), '0);
    ddr_ack = 1'b1;

    // basic two-beat transfer
    d0 = done_cnt;
    cmd(32'h1000, 19'h10, 64);
    wait_idle("t64");
    chk("t64_req0", DATA_W'(acc_log[0]), DATA_W'(32'h1000));
    chk("t64_req1", DATA_W'(acc_log[1]), DATA_W'(32'h1020));
    chk("t64_row0", DATA_W'(row_log[0]), DATA_W'(19'h10));
    chk("t64_row1", DATA_W'(row_log[1]), DATA_W'(19'h11));
    chk("t64_lb", DATA_W'(lb_log[1]), '0);
    chk("t64_done_cnt", DATA_W'(done_cnt - d0), DATA_W'(1));

    // unaligned address, partial last beat
    cmd(32'h1007, 19'h20, 33);
    wait_idle("t33");
    chk("t33_req0", DATA_W'(acc_log[0]), DATA_W'(32'h1000));
    chk("t33_beats", DATA_W'(row_log.size()), DATA_W'(2));
    chk("t33_lb", DATA_W'(lb_log[1]), DATA_W'(1));

    // zero length
    d0 = done_cnt;
    cmd(32'h3000, 19'h30, 0);
    wait_idle("t0");
    repeat (3) @(posedge clk);
    chk("t0_reqs", DATA_W'(acc_log.size()), '0);
    chk("t0_done_cnt", DATA_W'(done_cnt - d0), DATA_W'(1));

    // backpressure: ten beats with farm stalled, plus an ignored start while busy
    #1 farm_busy = 1'b1;
    cmd(32'h4000, 19'h100, 320);
    cmd(32'h9000, 19'h200, 64);
    repeat (18) @(posedge clk);
    #1;
    chk("stall_req_cap", DATA_W'(acc_log.size()), DATA_W'(4));
    farm_busy = 1'b0;
    wait_idle("t320");
    chk("t320_beats", DATA_W'(row_log.size()), DATA_W'(10));
    chk("t320_row9", DATA_W'(row_log[9]), DATA_W'(19'h109));

    // SRAM row wrap
    cmd(32'h5000, 19'h7FFFF, 64);
    wait_idle("twrap");
    chk("wrap_row0", DATA_W'(row_log[0]), DATA_W'(19'h7FFFF));
    chk("wrap_row1", DATA_W'(row_log[1]), '0);

    // random farm stalls with slower DDR returns
    ret_lat = 2;
    cmd(32'h6000, 19'h400, 200);
    n = 0;
    while ((m_busy || busy !== 1'b0) && n < 3000) begin
      @(posedge clk); #1;
      farm_busy = 1'($urandom_range(0, 1));
      n++;
    end
    farm_busy = 1'b0;
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL trand_timeout busy=%0b expected idle", busy);
    end
    chk("trand_beats", DATA_W'(row_log.size()), DATA_W'(7));
    chk("trand_lb", DATA_W'(lb_log[6]), DATA_W'(8));

    // reset during drain, stale returns afterwards
    ret_lat = 6;
    d0 = done_cnt;
    cmd(32'h7000, 19'h50, 64);
    n = 0;
    while (acc_log.size() < 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reqs", DATA_W'(acc_log.size()), DATA_W'(2));
    @(posedge clk); #1;
    ddr_ack = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ddr_ack = 1'b1; ret_lat = 0;
    n = 0;
    while (pend_addr.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    chk("abort_no_done", DATA_W'(done_cnt - d0), '0);
    chk("abort_idle_busy", DATA_W'(busy), '0);
    cmd(32'h2000, 19'h40, 32);
    wait_idle("tpost");
    chk("post_req0", DATA_W'(acc_log[0]), DATA_W'(32'h2000));
    chk("post_row0", DATA_W'(row_log[0]), DATA_W'(19'h40));
    chk("post_done_cnt", DATA_W'(done_cnt - d0), DATA_W'(1));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ddr_loader.md
MEM_DDR_LOADER -- requirements
Module: mem_ddr_loader

Interface
REQ-001 SHALL have parameters: DATA_W=256, beat width in bits; FIFO_DEPTH=4, return-data buffer entries (power of 2, 2..16); LEN_W=16, byte-length field width.
REQ-002 SHALL have one clock, clk; reset is synchronous and active-high.
REQ-003 Ports, clock and reset first:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- start in 1: single-cycle command strobe.
- cmd_ddr_addr in 32: DDR byte address.
- cmd_sram_addr in 19: first SRAM row.
- cmd_len in LEN_W: transfer length in bytes.
- busy out 1: command in progress.
- done out 1: one-cycle completion pulse.
- ddr_req out 1: DDR beat read request.
- ddr_addr out 32: request address.
- ddr_ack in 1: request accepted.
- ddr_valid in 1: return beat valid (no backpressure).
- ddr_data in DATA_W: return beat.
- farm_valid out 1: beat to memory-farm demux.
- farm_data out DATA_W: beat data.
- farm_base_addr out 19: SRAM row of this beat.
- farm_last out 1: final beat.
- farm_last_bytes out 5: valid bytes in final beat (0 = all 32).
- farm_busy in 1: demux stall; holds the current beat.

Function
REQ-004 SHALL implement FSM IDLE, FETCH, DRAIN, DONE; busy=1 in FETCH/DRAIN/DONE.
REQ-005 IDLE: on start with cmd_len!=0, SHALL latch command, compute beats=ceil(cmd_len/32), and go to FETCH next cycle. On start with cmd_len==0, SHALL go to DONE with no DDR request.
REQ-006 SHALL ignore start while busy=1.
REQ-007 SHALL force the low 5 bits of the DDR address to zero and increment ddr_addr by 32 per accepted request.
REQ-008 SHALL hold ddr_req and ddr_addr stable until ddr_ack; a request completes in the cycle req&ack=1.
REQ-009 SHALL assert ddr_req only while (outstanding requests + FIFO occupancy) < FIFO_DEPTH; overflow SHALL be impossible by construction.
REQ-010 SHALL push every ddr_valid beat into the FIFO. ddr_valid while in IDLE SHALL be discarded (stale return after reset).
REQ-011 FETCH to DRAIN SHALL occur when the last request is accepted; DRAIN to DONE SHALL occur when the last beat is transferred (farm_valid & !farm_busy & farm_last).
REQ-012 DONE SHALL assert done for exactly 1 cycle, then return to IDLE.
REQ-013 farm_valid SHALL be asserted when the FIFO is non-empty. A beat transfers when farm_valid & !farm_busy. While farm_busy=1, farm_data, farm_base_addr, farm_last and farm_last_bytes SHALL hold.
REQ-014 farm_base_addr SHALL start at cmd_sram_addr and increment by 1 per transferred beat, modulo 2^19 (wraps to 0).
REQ-015 farm_last SHALL be 1 only on the final beat, and farm_last_bytes SHALL be cmd_len[4:0] on that beat; on other beats farm_last_bytes SHALL be 0.
REQ-016 Latency: a beat SHALL appear on farm_* in the cycle after its ddr_valid, when the FIFO is empty and farm_busy=0.
REQ-017 A push and pop in the same cycle SHALL leave occupancy unchanged; a full FIFO with a simultaneous pop SHALL not stall requests for more than 1 cycle.

Reset
REQ-018 On rst: FSM=IDLE; FIFO emptied; outstanding=0; busy, done, ddr_req, farm_valid, farm_last=0; ddr_addr=0; farm_base_addr=0; farm_last_bytes=0.
REQ-019 Reset mid-transfer SHALL abort without a done pulse; the next start SHALL operate normally.

Configuration
REQ-020 With macro MEM_DDR_LOADER_STATS_EN defined, SHALL add outputs stat_beats (32, total beats transferred) and stat_stall (32, cycles with farm_valid&farm_busy). Both SHALL be cleared by rst, saturate at all-ones, and count across commands.
REQ-021 Without MEM_DDR_LOADER_STATS_EN, these ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-022 start, len=64, ddr addr 0x1000, sram 0x10, ack/valid immediate, no busy -> 2 requests (0x1000, 0x1020); beats at rows 0x10, 0x11; second has last=1, last_bytes=0; done 1 cycle later.
REQ-023 len=33 -> 2 beats, last_bytes=1; ddr addr 0x1007 -> first request at 0x1000.
REQ-024 len=0 -> no ddr_req; done pulses exactly once.
REQ-025 len=320 with farm_busy held 20 cycles -> ddr_req stops at 4 outstanding+buffered; no beat lost or duplicated; rows in order.
REQ-026 sram 0x7FFFF, len=64 -> rows 0x7FFFF then 0x00000.
REQ-027 rst during DRAIN, then stale ddr_valid in IDLE -> no farm_valid, no done; a following len=32 command completes correctly.
